// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win every cycle, CPU writes are posted
// into a small FIFO and drained when scanout is idle. Optional macro VRAM_ARB_OVF_CNT_EN adds OvfCount.
module vram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 14
) (
    input  logic              PxClock,
    input  logic              Reset,
    input  logic              CpuWrValid,
    input  logic [ADDR_W-1:0] CpuWrAddr,
    input  logic [7:0]        CpuWrData,
    output logic              CpuWrReady,
    input  logic              ScanReq,
    input  logic [ADDR_W-1:0] ScanAddr,
    output logic [7:0]        ScanData,
    output logic              ScanDataValid,
    output logic [ADDR_W-1:0] VramAddr,
    output logic [7:0]        VramWData,
    output logic              VramWE,
    input  logic [7:0]        VramRData,
`ifdef VRAM_ARB_OVF_CNT_EN
    output logic [7:0]        OvfCount,
`endif
    output logic              FifoEmpty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_vld_pipe;
    logic [7:0]        r_scan_data;

    logic w_full, w_empty, w_scan, w_pop, w_push;

    // Full/empty decode straight off the registered occupancy, so a same-cycle pop
    // never lets a full FIFO accept.
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_scan  = ScanReq && !Reset;
    assign w_pop   = !ScanReq && !w_empty && !Reset;
    assign w_push  = CpuWrValid && !w_full && !Reset;

    assign CpuWrReady    = !w_full;
    assign FifoEmpty     = w_empty;
    assign ScanData      = r_scan_data;
    assign ScanDataValid = r_vld_pipe[1];

    always_comb begin
        VramAddr  = '0;
        VramWData = '0;
        VramWE    = 1'b0;
        if (w_scan) begin
            VramAddr = ScanAddr;
        end else if (w_pop) begin
            VramAddr  = r_fifo_addr[r_rptr];
            VramWData = r_fifo_data[r_rptr];
            VramWE    = 1'b1;
        end
    end

    // Storage needs no reset; occupancy and pointers define what is live.
    always_ff @(posedge PxClock) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= CpuWrAddr;
            r_fifo_data[r_wptr] <= CpuWrData;
        end
    end

    always_ff @(posedge PxClock) begin
        if (Reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_vld_pipe  <= '0;
            r_scan_data <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            // Stage 0 marks the cycle VramRData carries the read; stage 1 is the output.
            r_vld_pipe <= {r_vld_pipe[0], w_scan};
            if (r_vld_pipe[0]) r_scan_data <= VramRData;
        end
    end

`ifdef VRAM_ARB_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;
    always_ff @(posedge PxClock) begin
        if (Reset)
            r_ovf_cnt <= '0;
        else if (CpuWrValid && w_full && r_ovf_cnt != 8'hFF)
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
    assign OvfCount = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model and a behavioural VRAM.
module tb_vram_arbiter;
    localparam int AW    = 14;
    localparam int DEPTH = 4;

    logic          PxClock;
    logic          Reset;
    logic          CpuWrValid;
    logic [AW-1:0] CpuWrAddr;
    logic [7:0]    CpuWrData;
    logic          CpuWrReady;
    logic          ScanReq;
    logic [AW-1:0] ScanAddr;
    logic [7:0]    ScanData;
    logic          ScanDataValid;
    logic [AW-1:0] VramAddr;
    logic [7:0]    VramWData;
    logic          VramWE;
    logic [7:0]    VramRData;
    logic          FifoEmpty;
`ifdef VRAM_ARB_OVF_CNT_EN
    logic [7:0]    OvfCount;
`endif

    vram_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .PxClock(PxClock), .Reset(Reset),
        .CpuWrValid(CpuWrValid), .CpuWrAddr(CpuWrAddr), .CpuWrData(CpuWrData),
        .CpuWrReady(CpuWrReady),
        .ScanReq(ScanReq), .ScanAddr(ScanAddr), .ScanData(ScanData),
        .ScanDataValid(ScanDataValid),
        .VramAddr(VramAddr), .VramWData(VramWData), .VramWE(VramWE),
        .VramRData(VramRData),
`ifdef VRAM_ARB_OVF_CNT_EN
        .OvfCount(OvfCount),
`endif
        .FifoEmpty(FifoEmpty)
    );

    initial PxClock = 1'b0;
    always #5 PxClock = ~PxClock;

    // Behavioural single-port VRAM with one-cycle read latency and a bench backdoor.
    logic [7:0]    vmem [0:(1<<AW)-1] = '{default: 8'h00};
    logic          bk_we = 1'b0;
    logic [AW-1:0] bk_addr = '0;
    logic [7:0]    bk_data = '0;
    always @(posedge PxClock) begin
        if (VramWE) vmem[VramAddr] <= VramWData;
        else if (bk_we) vmem[bk_addr] <= bk_data;
        VramRData <= vmem[VramAddr];
    end

    // Reference model: expected memory image, posted-write queue, scan pipeline.
    logic [7:0]    ref_mem [0:(1<<AW)-1] = '{default: 8'h00};
    logic [AW-1:0] q_a [$];
    logic [7:0]    q_d [$];
    logic          m_p0 = 1'b0;
    logic [7:0]    m_p0d = '0;
    logic          m_sdv = 1'b0;
    logic [7:0]    m_sd = '0;
    int            m_ovf = 0;

    int n_vec = 0;
    int n_err = 0;

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int sz;
        if (Reset) begin
            q_a.delete(); q_d.delete();
            m_p0 = 0; m_sdv = 0; m_sd = 0; m_ovf = 0;
        end else begin
            sz = q_a.size();
            m_sdv = m_p0;
            if (m_p0) m_sd = m_p0d;
            m_p0  = ScanReq;
            m_p0d = ref_mem[ScanAddr];
            if (!ScanReq && sz > 0) begin
                ref_mem[q_a[0]] = q_d[0];
                void'(q_a.pop_front()); void'(q_d.pop_front());
            end
            if (CpuWrValid) begin
                if (sz < DEPTH) begin
                    q_a.push_back(CpuWrAddr); q_d.push_back(CpuWrData);
                end else if (m_ovf < 255) m_ovf++;
            end
        end
    endtask

    // Called at the negedge: step the model, cross the rising edge, settle.
    task automatic tick();
        model_step();
        @(posedge PxClock);
        #1;
    endtask

    task automatic idle_inputs();
        CpuWrValid = 0; CpuWrAddr = '0; CpuWrData = '0;
        ScanReq = 0; ScanAddr = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        idle_inputs();
        bk_we = 1; bk_addr = a; bk_data = d;
        ref_mem[a] = d;
        @(negedge PxClock); tick();
        bk_we = 0;
    endtask

    task automatic test_reset();
        Reset = 1; CpuWrValid = 1; CpuWrAddr = 14'h0123; CpuWrData = 8'h5A;
        ScanReq = 1; ScanAddr = 14'h0042;
        @(negedge PxClock); tick();
        @(negedge PxClock);
        n_vec++; if (VramWE !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", VramWE); end
        n_vec++; if (CpuWrReady !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", CpuWrReady); end
        n_vec++; if (FifoEmpty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", FifoEmpty); end
        n_vec++; if (ScanDataValid !== 1'b0) begin n_err++; $display("FAIL rst_sdv got=%b exp=0", ScanDataValid); end
        n_vec++; if (ScanData !== 8'h00) begin n_err++; $display("FAIL rst_sd got=%h exp=00", ScanData); end
`ifdef VRAM_ARB_OVF_CNT_EN
        n_vec++; if (OvfCount !== 8'h00) begin n_err++; $display("FAIL rst_ovf got=%0d exp=0", OvfCount); end
`endif
        tick();
        Reset = 0; idle_inputs();
        @(negedge PxClock);
        n_vec++; if (VramAddr !== '0 || VramWE !== 1'b0 || VramWData !== 8'h00) begin
            n_err++; $display("FAIL idle_bus got=%h/%h/%b exp=0/0/0", VramAddr, VramWData, VramWE); end
        tick();
    endtask

    task automatic test_single_write();
        CpuWrValid = 1; CpuWrAddr = 14'h0001; CpuWrData = 8'h00;
        @(negedge PxClock);
        n_vec++; if (CpuWrReady !== 1'b1) begin n_err++; $display("FAIL wr_ready got=%b exp=1", CpuWrReady); end
        tick();
        idle_inputs();
        @(negedge PxClock);
        n_vec++; if (VramWE !== 1'b1 || VramAddr !== 14'h0001 || VramWData !== 8'h00) begin
            n_err++; $display("FAIL wr_drain got=%b/%h/%h exp=1/0001/00", VramWE, VramAddr, VramWData); end
        n_vec++; if (FifoEmpty !== 1'b0) begin n_err++; $display("FAIL wr_pending got=%b exp=0", FifoEmpty); end
        tick();
        @(negedge PxClock);
        n_vec++; if (FifoEmpty !== 1'b1 || VramWE !== 1'b0) begin
            n_err++; $display("FAIL wr_done got=%b/%b exp=1/0", FifoEmpty, VramWE); end
        tick();
    endtask

    task automatic test_scan_stream();
        logic [7:0] want;
        for (int i = 0; i < 10; i++) preload(AW'(i), 8'(i));
        for (int c = 0; c < 12; c++) begin
            ScanReq = (c < 10); ScanAddr = AW'(c);
            @(negedge PxClock);
            n_vec++; if (VramWE !== 1'b0) begin n_err++; $display("FAIL scan_we c=%0d got=%b exp=0", c, VramWE); end
            n_vec++; if (ScanDataValid !== (c >= 2)) begin
                n_err++; $display("FAIL scan_sdv c=%0d got=%b exp=%b", c, ScanDataValid, c >= 2); end
            if (c >= 2) begin
                want = 8'(c - 2);
                n_vec++; if (ScanData !== want) begin
                    n_err++; $display("FAIL scan_data c=%0d got=%h exp=%h", c, ScanData, want); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        ScanReq = 1; ScanAddr = 14'h3000;
        for (int i = 0; i < 5; i++) begin
            CpuWrValid = 1; CpuWrAddr = AW'(14'h0100 + i); CpuWrData = 8'(8'h10 + i);
            @(negedge PxClock);
            n_vec++; if (CpuWrReady !== (i < 4)) begin
                n_err++; $display("FAIL ovf_ready i=%0d got=%b exp=%b", i, CpuWrReady, i < 4); end
            tick();
        end
        CpuWrValid = 0;
        @(negedge PxClock);
        n_vec++; if (CpuWrReady !== 1'b0 || FifoEmpty !== 1'b0 || VramWE !== 1'b0) begin
            n_err++; $display("FAIL ovf_full got=%b/%b/%b exp=0/0/0", CpuWrReady, FifoEmpty, VramWE); end
`ifdef VRAM_ARB_OVF_CNT_EN
        n_vec++; if (OvfCount !== 8'd1) begin n_err++; $display("FAIL ovf_count got=%0d exp=1", OvfCount); end
`endif
        tick();
        ScanReq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PxClock);
            n_vec++; if (VramWE !== 1'b1 || VramAddr !== AW'(14'h0100 + i) || VramWData !== 8'(8'h10 + i)) begin
                n_err++; $display("FAIL ovf_drain i=%0d got=%b/%h/%h exp=1/%h/%h", i, VramWE, VramAddr,
                                  VramWData, AW'(14'h0100 + i), 8'(8'h10 + i)); end
            tick();
        end
        @(negedge PxClock);
        n_vec++; if (FifoEmpty !== 1'b1 || VramWE !== 1'b0 || CpuWrReady !== 1'b1) begin
            n_err++; $display("FAIL ovf_end got=%b/%b/%b exp=1/0/1", FifoEmpty, VramWE, CpuWrReady); end
        tick();
    endtask

    task automatic test_hazard();
        preload(14'h2000, 8'h55);
        CpuWrValid = 1; CpuWrAddr = 14'h2000; CpuWrData = 8'hAA;
        ScanReq = 1; ScanAddr = 14'h2000;
        @(negedge PxClock);
        n_vec++; if (VramWE !== 1'b0 || VramAddr !== 14'h2000) begin
            n_err++; $display("FAIL haz_scan got=%b/%h exp=0/2000", VramWE, VramAddr); end
        tick();
        idle_inputs();
        @(negedge PxClock);
        n_vec++; if (VramWE !== 1'b1 || VramAddr !== 14'h2000 || VramWData !== 8'hAA) begin
            n_err++; $display("FAIL haz_drain got=%b/%h/%h exp=1/2000/aa", VramWE, VramAddr, VramWData); end
        tick();
        ScanReq = 1; ScanAddr = 14'h2000;
        @(negedge PxClock);
        n_vec++; if (ScanDataValid !== 1'b1 || ScanData !== 8'h55) begin
            n_err++; $display("FAIL haz_old got=%b/%h exp=1/55", ScanDataValid, ScanData); end
        tick();
        idle_inputs();
        @(negedge PxClock); tick();
        @(negedge PxClock);
        n_vec++; if (ScanDataValid !== 1'b1 || ScanData !== 8'hAA) begin
            n_err++; $display("FAIL haz_new got=%b/%h exp=1/aa", ScanDataValid, ScanData); end
        tick();
    endtask

    task automatic test_reset_mid();
        ScanReq = 1; ScanAddr = 14'h0005;
        for (int i = 0; i < 3; i++) begin
            CpuWrValid = 1; CpuWrAddr = AW'(14'h0200 + i); CpuWrData = 8'(8'hC0 + i);
            @(negedge PxClock); tick();
        end
        Reset = 1;
        @(negedge PxClock);
        n_vec++; if (FifoEmpty !== 1'b0 || VramWE !== 1'b0) begin
            n_err++; $display("FAIL rmid_pre got=%b/%b exp=0/0", FifoEmpty, VramWE); end
        tick();
        Reset = 0; idle_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge PxClock);
            n_vec++; if (VramWE !== 1'b0 || ScanDataValid !== 1'b0 || FifoEmpty !== 1'b1 || CpuWrReady !== 1'b1) begin
                n_err++; $display("FAIL rmid_post c=%0d got we=%b sdv=%b empty=%b ready=%b exp 0/0/1/1",
                                  c, VramWE, ScanDataValid, FifoEmpty, CpuWrReady); end
            tick();
        end
    endtask

    task automatic test_random();
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_wd;
        int            sz;
        for (int n = 0; n < 2000; n++) begin
            Reset      = ($urandom_range(0, 63) == 0);
            ScanReq    = ($urandom_range(0, 1) == 1);
            ScanAddr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            CpuWrValid = ($urandom_range(0, 9) < 4);
            CpuWrAddr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            CpuWrData  = 8'($urandom);
            @(negedge PxClock);
            sz     = q_a.size();
            e_we   = !Reset && !ScanReq && sz > 0;
            e_addr = Reset ? '0 : ScanReq ? ScanAddr : (sz > 0) ? q_a[0] : '0;
            e_wd   = e_we ? q_d[0] : 8'h00;
            n_vec++; if (VramWE !== e_we) begin n_err++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, VramWE, e_we); end
            n_vec++; if (VramAddr !== e_addr) begin n_err++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, VramAddr, e_addr); end
            if (e_we) begin
                n_vec++; if (VramWData !== e_wd) begin n_err++; $display("FAIL rnd_wd n=%0d got=%h exp=%h", n, VramWData, e_wd); end
            end
            n_vec++; if (CpuWrReady !== (sz < DEPTH)) begin
                n_err++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, CpuWrReady, sz < DEPTH); end
            n_vec++; if (FifoEmpty !== (sz == 0)) begin
                n_err++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, FifoEmpty, sz == 0); end
            n_vec++; if (ScanDataValid !== m_sdv) begin
                n_err++; $display("FAIL rnd_sdv n=%0d got=%b exp=%b", n, ScanDataValid, m_sdv); end
            n_vec++; if (ScanData !== m_sd) begin n_err++; $display("FAIL rnd_sd n=%0d got=%h exp=%h", n, ScanData, m_sd); end
`ifdef VRAM_ARB_OVF_CNT_EN
            n_vec++; if (OvfCount !== 8'(m_ovf)) begin
                n_err++; $display("FAIL rnd_ovf n=%0d got=%0d exp=%0d", n, OvfCount, m_ovf); end
`endif
            tick();
        end
        Reset = 0; idle_inputs();
    endtask

    initial begin
        Reset = 1;
        idle_inputs();
        #1;
        test_reset();
        test_single_write();
        test_scan_stream();
        test_overflow();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the CPU write post-buffer depth; legal values are powers of two from 2 to 16.
REQ-002 Parameter ADDR_W, default 14, is the VRAM word address width (16K x 8).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 PxClock  in  1  pixel clock; sole clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 CpuWrValid  in  1  one-cycle pulse per CPU VRAM write, already synchronized to PxClock.
REQ-007 CpuWrAddr  in  ADDR_W  CPU write address.
REQ-008 CpuWrData  in  8  CPU write data.
REQ-009 CpuWrReady  out  1  post buffer not full.
REQ-010 ScanReq  in  1  scanout fetch request this cycle.
REQ-011 ScanAddr  in  ADDR_W  scanout fetch address.
REQ-012 ScanData  out  8  fetched pixel byte.
REQ-013 ScanDataValid  out  1  ScanData valid this cycle.
REQ-014 VramAddr  out  ADDR_W  single-port VRAM address.
REQ-015 VramWData  out  8  VRAM write data.
REQ-016 VramWE  out  1  VRAM write enable.
REQ-017 VramRData  in  8  VRAM read data, valid one cycle after its address is presented.
REQ-018 FifoEmpty  out  1  no posted writes pending.

Function
REQ-019 Per-cycle grant is evaluated in this order: SCAN if ScanReq=1; else DRAIN if the FIFO is non-empty; else IDLE.
REQ-020 SCAN drives VramAddr=ScanAddr and VramWE=0 combinationally in the same cycle N.
REQ-021 The SCAN response is registered: ScanData=VramRData captured at the end of N+1, and ScanDataValid=1 in cycle N+2; the fixed latency is 2 cycles and back-to-back requests are serviced every cycle.
REQ-022 DRAIN drives VramAddr, VramWData and VramWE=1 from the FIFO head and pops one entry at the clock edge.
REQ-023 IDLE drives VramAddr=0, VramWData=0 and VramWE=0.
REQ-024 A push occurs when CpuWrValid=1 and CpuWrReady=1; a write presented with CpuWrReady=0 is dropped.
REQ-025 CpuWrReady is equal to !full based on the registered occupancy; a pop in the same cycle does not make a full FIFO accept.
REQ-026 A simultaneous push and pop on a non-full FIFO leaves occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 Writes drain in strict arrival order.
REQ-028 A scan read of an address still pending in the FIFO returns the old VRAM contents; no forwarding is performed.
REQ-029 A continuous ScanReq stalls draining indefinitely; CPU software is responsible for writing during blanking.
REQ-030 FifoEmpty is equal to (occupancy==0), registered.

Reset
REQ-031 On Reset=1 at a clock edge: the FIFO is flushed with occupancy 0, CpuWrReady=1, FifoEmpty=1, ScanDataValid=0, ScanData=0, and any in-flight scan responses are discarded.
REQ-032 While Reset=1, VramWE=0, and CpuWrValid and ScanReq are ignored.
REQ-033 Reset asserted mid-drain loses all pending writes; no partial write is issued after the reset edge.

Configuration
REQ-034 With macro VRAM_ARB_OVF_CNT_EN defined, output OvfCount (8 bits) SHALL count dropped writes (REQ-024), saturate at 255, and reset to 0.
REQ-035 Without VRAM_ARB_OVF_CNT_EN, the OvfCount port and its counter are absent, and drops are silent.

Verification
REQ-036 Reset, then push 0x0001/0x00 with ScanReq=0 -> VramWE=1, VramAddr=0x0001 within 2 cycles, then FifoEmpty=1.
REQ-037 Hold ScanReq=1 for 10 cycles with addresses 0x0000..0x0009 preloaded to value=addr -> ScanDataValid on cycles 2..11 with data 0x00..0x09, and VramWE=0 throughout.
REQ-038 With ScanReq=1, push 5 writes at FIFO_DEPTH=4 -> 4 accepted, CpuWrReady=0, 5th dropped (OvfCount=1 with macro); drop ScanReq -> 4 writes drain in order over 4 cycles.
REQ-039 Push 0x2000/0xAA and read 0x2000 in the same cycle with ScanReq=1 -> ScanData is the old value; a read after drain returns 0xAA.
REQ-040 Fill the FIFO to 3 entries, assert Reset for 1 cycle -> no VramWE afterwards, FifoEmpty=1, CpuWrReady=1, and no ScanDataValid for pre-reset requests.
